// File: rtl/mdio_pkg.sv
// Shared MDIO arbiter definitions: field widths, default timeout, FSM states.
package mdio_pkg;

   localparam int MDIO_ADDR_W      = 5;
   localparam int MDIO_DATA_W      = 16;
   localparam int MDIO_CNT_W       = 16;
   localparam int MDIO_TIMEOUT_CYC = 2048;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } mdio_state_e;

   // Read data handed back to a requester: writes never return data.
   function automatic logic [MDIO_DATA_W-1:0] mdio_rd_data_sel(
      input logic                   rh_wl,
      input logic [MDIO_DATA_W-1:0] data
   );
      return rh_wl ? data : {MDIO_DATA_W{1'b0}};
   endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Combinational round-robin picker: first active request after last_grant.
module mdio_rr_pick
   import mdio_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int GW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    last_grant,
   output logic [GW-1:0]    grant,
   output logic             any_req
);

   int idx_s;

   // Scan from last_grant+1 around the ring; the first requester found wins.
   always_comb begin
      grant   = {GW{1'b0}};
      any_req = 1'b0;
      idx_s   = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx_s = (int'(last_grant) + off) % N_REQ;
         if (!any_req && req[idx_s]) begin
            grant   = GW'(idx_s);
            any_req = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO driver between N_REQ requesters,
// with a per-operation timeout and a drain phase for late driver completions.
module mdio_arbiter
   import mdio_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = MDIO_TIMEOUT_CYC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0]             req_rh_wl,
   input  logic [MDIO_ADDR_W*N_REQ-1:0] req_addr,
   input  logic [MDIO_DATA_W*N_REQ-1:0] req_wr_data,
   output logic [N_REQ-1:0]             req_done,
   output logic [MDIO_DATA_W-1:0]       req_rd_data,
   output logic                         req_rd_ack,
   output logic                         req_timeout,
   output logic                         busy,
   output logic                         op_exec,
   output logic                         op_rh_wl,
   output logic [MDIO_ADDR_W-1:0]       op_addr,
   output logic [MDIO_DATA_W-1:0]       op_wr_data,
   input  logic                         op_done,
   input  logic [MDIO_DATA_W-1:0]       op_rd_data,
   input  logic                         op_rd_ack
);

   localparam int                    GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [MDIO_CNT_W-1:0] CNT_LAST  = MDIO_CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0]         GRANT_RST = GW'(N_REQ - 1);

   mdio_state_e             state_r, state_s;
   logic [GW-1:0]           grant_r, grant_s;
   logic [GW-1:0]           last_grant_r, last_grant_s;
   logic [MDIO_CNT_W-1:0]   cnt_r, cnt_s;
   logic [GW-1:0]           pick_s;
   logic                    any_req_s;

   logic                    op_exec_s;
   logic                    op_rh_wl_s;
   logic [MDIO_ADDR_W-1:0]  op_addr_s;
   logic [MDIO_DATA_W-1:0]  op_wr_data_s;
   logic [N_REQ-1:0]        req_done_s;
   logic [MDIO_DATA_W-1:0]  req_rd_data_s;
   logic                    req_rd_ack_s;
   logic                    req_timeout_s;
   logic                    busy_s;

   mdio_rr_pick #(
      .N_REQ (N_REQ),
      .GW    (GW)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .grant      (pick_s),
      .any_req    (any_req_s)
   );

   // Next-state and next-output logic; op_* and result fields hold by default.
   always_comb begin
      state_s       = state_r;
      grant_s       = grant_r;
      last_grant_s  = last_grant_r;
      cnt_s         = cnt_r;
      op_exec_s     = 1'b0;
      op_rh_wl_s    = op_rh_wl;
      op_addr_s     = op_addr;
      op_wr_data_s  = op_wr_data;
      req_done_s    = {N_REQ{1'b0}};
      req_rd_data_s = req_rd_data;
      req_rd_ack_s  = req_rd_ack;
      req_timeout_s = req_timeout;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               grant_s      = pick_s;
               op_exec_s    = 1'b1;
               op_rh_wl_s   = req_rh_wl[pick_s];
               op_addr_s    = req_addr[int'(pick_s)*MDIO_ADDR_W +: MDIO_ADDR_W];
               op_wr_data_s = req_wr_data[int'(pick_s)*MDIO_DATA_W +: MDIO_DATA_W];
               cnt_s        = {MDIO_CNT_W{1'b0}};
               state_s      = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // A completion arriving on the timeout cycle is still a normal completion.
            if (op_done) begin
               req_done_s[grant_r] = 1'b1;
               req_rd_data_s       = mdio_rd_data_sel(op_rh_wl, op_rd_data);
               req_rd_ack_s        = op_rd_ack;
               req_timeout_s       = 1'b0;
               last_grant_s        = grant_r;
               state_s             = ST_IDLE;
            end else if (cnt_r == CNT_LAST) begin
               req_done_s[grant_r] = 1'b1;
               req_rd_data_s       = {MDIO_DATA_W{1'b0}};
               req_rd_ack_s        = 1'b1;
               req_timeout_s       = 1'b1;
               last_grant_s        = grant_r;
               cnt_s               = {MDIO_CNT_W{1'b0}};
               state_s             = ST_DRAIN;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         ST_DRAIN: begin
            // The driver may still finish the abandoned op; swallow it silently.
            if (op_done || (cnt_r == CNT_LAST)) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_r      <= {GW{1'b0}};
         last_grant_r <= GRANT_RST;
         cnt_r        <= {MDIO_CNT_W{1'b0}};
         op_exec      <= 1'b0;
         op_rh_wl     <= 1'b0;
         op_addr      <= {MDIO_ADDR_W{1'b0}};
         op_wr_data   <= {MDIO_DATA_W{1'b0}};
         req_done     <= {N_REQ{1'b0}};
         req_rd_data  <= {MDIO_DATA_W{1'b0}};
         req_rd_ack   <= 1'b1;
         req_timeout  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         last_grant_r <= last_grant_s;
         cnt_r        <= cnt_s;
         op_exec      <= op_exec_s;
         op_rh_wl     <= op_rh_wl_s;
         op_addr      <= op_addr_s;
         op_wr_data   <= op_wr_data_s;
         req_done     <= req_done_s;
         req_rd_data  <= req_rd_data_s;
         req_rd_ack   <= req_rd_ack_s;
         req_timeout  <= req_timeout_s;
         busy         <= busy_s;
      end
   end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: completions expected per operation are
// queued when the driver is told to respond and checked when req_done fires.
module tb_mdio_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_rh_wl;
   logic [5*N-1:0]  req_addr;
   logic [16*N-1:0] req_wr_data;
   logic [N-1:0]  req_done;
   logic [15:0]   req_rd_data;
   logic          req_rd_ack;
   logic          req_timeout;
   logic          busy;
   logic          op_exec;
   logic          op_rh_wl;
   logic [4:0]    op_addr;
   logic [15:0]   op_wr_data;
   logic          op_done;
   logic [15:0]   op_rd_data;
   logic          op_rd_ack;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      int          idx;
      logic [15:0] data;
      logic        ack;
      logic        to;
   } exp_t;

   exp_t exp_q[$];

   mdio_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_rh_wl   (req_rh_wl),
      .req_addr    (req_addr),
      .req_wr_data (req_wr_data),
      .req_done    (req_done),
      .req_rd_data (req_rd_data),
      .req_rd_ack  (req_rd_ack),
      .req_timeout (req_timeout),
      .busy        (busy),
      .op_exec     (op_exec),
      .op_rh_wl    (op_rh_wl),
      .op_addr     (op_addr),
      .op_wr_data  (op_wr_data),
      .op_done     (op_done),
      .op_rd_data  (op_rd_data),
      .op_rd_ack   (op_rd_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic rh,
                          input logic [4:0] a, input logic [15:0] d);
      req_valid[i]         = v;
      req_rh_wl[i]         = rh;
      req_addr[i*5 +: 5]   = a;
      req_wr_data[i*16 +: 16] = d;
   endtask

   task automatic wait_exec(input int budget, output int lat);
      lat = 0;
      while (op_exec !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (op_exec !== 1'b1) chk("exec_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic serve(input logic [15:0] d, input logic a);
      op_done    = 1'b1;
      op_rd_data = d;
      op_rd_ack  = a;
      @(negedge clk);
      op_done    = 1'b0;
      op_rd_data = 16'h0000;
      op_rd_ack  = 1'b0;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_op_exec"},    32'(op_exec),     32'd0);
      chk({pfx, "_op_rh_wl"},   32'(op_rh_wl),    32'd0);
      chk({pfx, "_op_addr"},    32'(op_addr),     32'd0);
      chk({pfx, "_op_wr_data"}, 32'(op_wr_data),  32'd0);
      chk({pfx, "_req_done"},   32'(req_done),    32'd0);
      chk({pfx, "_rd_data"},    32'(req_rd_data), 32'd0);
      chk({pfx, "_rd_ack"},     32'(req_rd_ack),  32'd1);
      chk({pfx, "_timeout"},    32'(req_timeout), 32'd0);
      chk({pfx, "_busy"},       32'(busy),        32'd0);
   endtask

   // Completion monitor: every req_done pulse must match the oldest expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (req_done !== 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'(req_done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_vec",     32'(req_done),    32'(4'b0001 << e.idx));
            chk("done_rd_data", 32'(req_rd_data), 32'(e.data));
            chk("done_rd_ack",  32'(req_rd_ack),  32'(e.ack));
            chk("done_timeout", 32'(req_timeout), 32'(e.to));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int lat;
      req_valid   = 4'b0000;
      req_rh_wl   = 4'b0000;
      req_addr    = 20'h00000;
      req_wr_data = 64'h0;
      op_done     = 1'b0;
      op_rd_data  = 16'h0000;
      op_rd_ack   = 1'b0;
      rst         = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);

      // Single read on requester 2.
      set_req(2, 1'b1, 1'b1, 5'h19, 16'h0000);
      @(negedge clk);
      chk("rd_exec_lat", 32'(op_exec),  32'd1);
      chk("rd_addr",     32'(op_addr),  32'h19);
      chk("rd_rh_wl",    32'(op_rh_wl), 32'd1);
      chk("rd_busy",     32'(busy),     32'd1);
      @(negedge clk);
      chk("rd_exec_pulse", 32'(op_exec), 32'd0);
      exp_q.push_back('{2, 16'hAC04, 1'b0, 1'b0});
      serve(16'hAC04, 1'b0);
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk("rd_busy_idle", 32'(busy), 32'd0);

      // Write on requester 1; op fields must hold while the requester changes.
      set_req(1, 1'b1, 1'b0, 5'h00, 16'hB100);
      wait_exec(10, lat);
      chk("wr_rh_wl", 32'(op_rh_wl),   32'd0);
      chk("wr_addr",  32'(op_addr),    32'd0);
      chk("wr_data",  32'(op_wr_data), 32'hB100);
      req_wr_data[16 +: 16] = 16'h5555;
      req_addr[5 +: 5]      = 5'h1F;
      repeat (5) @(negedge clk);
      chk("wr_hold_data", 32'(op_wr_data), 32'hB100);
      chk("wr_hold_addr", 32'(op_addr),    32'd0);
      exp_q.push_back('{1, 16'h0000, 1'b0, 1'b0});
      serve(16'hFFFF, 1'b0);
      req_valid[1] = 1'b0;
      @(negedge clk);

      // Timeout on requester 3, then drain with a late completion.
      set_req(3, 1'b1, 1'b1, 5'h07, 16'h0000);
      wait_exec(10, lat);
      exp_q.push_back('{3, 16'h0000, 1'b1, 1'b1});
      lat = 0;
      while (req_done === 4'b0000 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      req_valid[3] = 1'b0;
      chk("to_latency", 32'(lat), 32'd2048);
      set_req(0, 1'b1, 1'b1, 5'h0A, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         chk("drain_busy",    32'(busy),    32'd1);
         chk("drain_no_exec", 32'(op_exec), 32'd0);
      end
      serve(16'h1234, 1'b0);
      chk("drain_exit_busy", 32'(busy), 32'd0);
      wait_exec(5, lat);
      chk("post_drain_lat",  32'(lat),     32'd1);
      chk("post_drain_addr", 32'(op_addr), 32'h0A);
      exp_q.push_back('{0, 16'h0BEE, 1'b0, 1'b0});
      serve(16'h0BEE, 1'b0);
      req_valid[0] = 1'b0;
      @(negedge clk);

      // Reset while an op is outstanding; stale op_done must be ignored.
      set_req(2, 1'b1, 1'b1, 5'h19, 16'h0000);
      wait_exec(10, lat);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'b0000;
      @(negedge clk);
      chk_reset_vals("wrst");
      rst = 1'b0;
      serve(16'hDEAD, 1'b0);
      @(negedge clk);
      chk("wrst_idle_busy", 32'(busy), 32'd0);

      // Contention: all four held high, expect 0,1,2,3,0 with exec pulses two apart.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 5'(5'h10 + i), 16'h0000);
      for (int k = 0; k < 5; k++) begin
         wait_exec(10, lat);
         chk("cont_lat",  32'(lat),     32'd1);
         chk("cont_addr", 32'(op_addr), 32'(5'h10 + (k % N)));
         exp_q.push_back('{k % N, 16'(16'hC000 + k), 1'b0, 1'b0});
         serve(16'(16'hC000 + k), 1'b0);
         if (k == 4) req_valid = 4'b0000;
      end
      repeat (3) @(negedge clk);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      chk("final_busy",    32'(busy),         32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the MDIO driver.
REQ-002 Parameter TIMEOUT_CYC, default 2048: clk cycles allowed in WAIT before timeout.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset: clk in 1 (driver clock domain); rst in 1 (sync, active-high).
REQ-004 Requester-side ports SHALL be: req_valid in N_REQ (level request per requester, held until its req_done); req_rh_wl in N_REQ (1 read, 0 write); req_addr in 5*N_REQ (packed reg addr, requester i at [5i+4:5i]); req_wr_data in 16*N_REQ (packed write data).
REQ-005 Requester-side outputs SHALL be: req_done out N_REQ (one-hot 1-cycle completion pulse); req_rd_data out 16 (read data, valid with req_done); req_rd_ack out 1 (0 ack, 1 no-ack/failed); req_timeout out 1 (1 = op timed out, valid with req_done); busy out 1 (state != IDLE).
REQ-006 Driver-side ports SHALL be: op_exec out 1 (1-cycle start pulse); op_rh_wl out 1; op_addr out 5; op_wr_data out 16; op_done in 1; op_rd_data in 16; op_rd_ack in 1.

Function
REQ-007 States SHALL be IDLE, WAIT, DRAIN; all outputs registered.
REQ-008 IDLE: if any req_valid, the arbiter SHALL pick by round-robin, starting search at last_grant+1 modulo N_REQ, latch index into grant, copy that requester's rh_wl/addr/wr_data into op_*, assert op_exec for exactly one cycle on the next edge, enter WAIT.
REQ-009 Latency SHALL be: req_valid sampled at edge k -> op_exec high in cycle after edge k.
REQ-010 op_rh_wl/op_addr/op_wr_data SHALL hold stable from op_exec until the op ends.
REQ-011 WAIT: on op_done, the arbiter SHALL register op_rd_data/op_rd_ack into req_rd_data/req_rd_ack, pulse req_done[grant] one cycle, req_timeout=0, update last_grant=grant, enter IDLE.
REQ-012 For writes, req_rd_data SHALL be 0 and req_rd_ack SHALL pass op_rd_ack through.
REQ-013 WAIT timeout counter (16 bit, cleared on WAIT entry): at count TIMEOUT_CYC-1 without op_done, pulse req_done[grant] with req_timeout=1, req_rd_ack=1, req_rd_data=0, update last_grant, enter DRAIN.
REQ-014 DRAIN: wait for op_done (discarded, no req_done) or a further TIMEOUT_CYC cycles, then enter IDLE; no op_exec issued in DRAIN.
REQ-015 op_done in IDLE or DRAIN-exit cycle SHALL be ignored; op_done and timeout in same cycle -> op_done wins (normal completion).
REQ-016 req_valid deasserted mid-operation SHALL not abort; req_done still pulses.
REQ-017 Arbitration resumes in the cycle after return to IDLE; back-to-back ops SHALL have op_exec pulses at least 2 cycles apart.
REQ-018 A requester's req_valid still high in the cycle of its own req_done SHALL not be re-granted before other pending requesters (round-robin fairness).

Reset
REQ-019 On rst: state=IDLE, op_exec=0, op_rh_wl=0, op_addr=0, op_wr_data=0, req_done=0, req_rd_data=0, req_rd_ack=1, req_timeout=0, busy=0, counter=0, last_grant=N_REQ-1 (requester 0 highest priority).
REQ-020 rst mid-operation SHALL abort without a req_done pulse; driver-side op_done after reset SHALL be ignored.

Structure
REQ-021 Shared package mdio_pkg SHALL hold the state enum, MDIO_ADDR_W=5, MDIO_DATA_W=16, and the default TIMEOUT_CYC.
REQ-022 Round-robin selection SHALL be a combinational sub-module mdio_rr_pick (inputs req vector, last_grant; outputs grant index, any_req).

Verification
REQ-023 Single read: req_valid[2]=1, addr 5'h19 -> op_exec 1 cycle, op_addr=5'h19, op_rh_wl=1; op_done with rd_data 16'hAC04, ack 0 -> req_done=4'b0100, req_rd_data=16'hAC04, req_rd_ack=0.
REQ-024 Contention: all four req_valid held high after reset -> grant order 0,1,2,3,0; each req_done one-hot, one per op.
REQ-025 Timeout: no op_done for 2048 cycles -> req_done pulse with req_timeout=1, req_rd_ack=1, busy stays 1 in DRAIN; late op_done -> IDLE, no extra req_done.
REQ-026 Write hold: req 1 write addr 0 data 16'hB100, change req_wr_data during WAIT -> op_wr_data stays 16'hB100 until op_done.
REQ-027 Reset in WAIT: assert rst -> next cycle all outputs at reset values, no req_done; next request granted to requester 0 first.
